dff_pair: RTL and testbench

//  - Two parallel D-flip-flop register paths fed by one data input, for comparing flop styles.
//  - Path A (q) is a plain edge-triggered register with no reset.
//  - Path B (q2) is the same register with a synchronous, active-high reset.
//  - Used as a leaf timing/sampling primitive and as a teaching reference for reset semantics.

---
 rtl/dff_stage.sv | 32 +++
 rtl/dff_pair.sv | 58 +++++
 tb/tb_dff_pair.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dff_stage.sv
// One WIDTH-bit edge-triggered register with an optional synchronous, active-high reset.
// It is the building block of both register chains in dff_pair.
`timescale 1ns/1ps

module dff_stage #(
  parameter int unsigned      WIDTH   = 1,
  parameter bit               HAS_RST = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (HAS_RST) begin : g_rst
    // NOTE: non-blocking assignment, so a d that changes on the same edge is sampled at its old value.
    always_ff @(posedge clk) begin
      if (reset) q <= RST_VAL;
      else       q <= d;
    end
  end else begin : g_norst
    // NOTE: this flop has no reset. It powers up unknown and becomes valid once it has sampled a known d.
    logic unused_reset;
    assign unused_reset = reset;

    always_ff @(posedge clk) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_pair.sv
// Two parallel DEPTH-stage register chains fed by one input. Chain A (q) has no reset.
// Chain B (q2) loads RST_VAL into every stage on a synchronous, active-high reset.
`timescale 1ns/1ps

module dff_pair #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q2
);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_pair: WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pair: DEPTH must be >= 1");
  end

  // Entry 0 of each chain is the shared input. Entry i+1 is the output of stage i.
  logic [WIDTH-1:0] a_chain [DEPTH+1];
  logic [WIDTH-1:0] b_chain [DEPTH+1];

  assign a_chain[0] = d;
  assign b_chain[0] = d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(
      .WIDTH  (WIDTH),
      .HAS_RST(1'b0),
      .RST_VAL(RST_VAL)
    ) u_a (
      .clk  (clk),
      .reset(reset),
      .d    (a_chain[i]),
      .q    (a_chain[i+1])
    );

    dff_stage #(
      .WIDTH  (WIDTH),
      .HAS_RST(1'b1),
      .RST_VAL(RST_VAL)
    ) u_b (
      .clk  (clk),
      .reset(reset),
      .d    (b_chain[i]),
      .q    (b_chain[i+1])
    );
  end

  assign q  = a_chain[DEPTH];
  assign q2 = b_chain[DEPTH];

endmodule

// File: tb/tb_dff_pair.sv
// Self-checking bench for dff_pair. Three configurations share the same stimulus and are compared
// against a history model: q is d from DEPTH edges ago, and q2 is RST_VAL if any of the last DEPTH edges sampled reset.
`timescale 1ns/10ps

module tb_dff_pair;

  logic       clk = 1'b0;
  logic       rst_drv;
  logic [7:0] d_drv;

  logic       q_1, q2_1;
  logic [7:0] q_3, q2_3, q_4, q2_4;

  int checks = 0;
  int errors = 0;

  // Values sampled at each rising edge, oldest first.
  logic [7:0] hist_d [$];
  logic       hist_r [$];

  always #1 clk = ~clk;

  dff_pair #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u1 (
    .clk(clk), .reset(rst_drv), .d(d_drv[0]), .q(q_1), .q2(q2_1));

  dff_pair #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u3 (
    .clk(clk), .reset(rst_drv), .d(d_drv), .q(q_3), .q2(q2_3));

  dff_pair #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u4 (
    .clk(clk), .reset(rst_drv), .d(d_drv), .q(q_4), .q2(q2_4));

  function automatic logic [7:0] exp_q(int dep);
    return hist_d[hist_d.size() - dep];
  endfunction

  function automatic logic [7:0] exp_q2(int dep, logic [7:0] rv);
    int n = hist_r.size();
    for (int k = n - dep; k < n; k++)
      if (hist_r[k]) return rv;
    return hist_d[n - dep];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int n = hist_d.size();
    if (n >= 1) begin
      check("w1d1_q",  {7'b0, q_1},  exp_q(1) & 8'h01);
      check("w1d1_q2", {7'b0, q2_1}, exp_q2(1, 8'h00) & 8'h01);
    end
    if (n >= 3) begin
      check("w8d3_q",  q_3,  exp_q(3));
      check("w8d3_q2", q2_3, exp_q2(3, 8'hA5));
    end
    if (n >= 4) begin
      check("w8d4_q",  q_4,  exp_q(4));
      check("w8d4_q2", q2_4, exp_q2(4, 8'h5A));
    end
  endtask

  task automatic record();
    hist_d.push_back(d_drv);
    hist_r.push_back(rst_drv);
  endtask

  // Inputs change at the falling edge, then one rising edge is taken and the outputs are checked at the next falling edge.
  task automatic step(input logic [7:0] dv, input logic rv);
    d_drv   = dv;
    rst_drv = rv;
    @(posedge clk);
    record();
    @(negedge clk);
    check_all();
  endtask

  // reset glitches to the opposite level for 0.25 ns, starting and ending between edges.
  task automatic glitch_step(input logic [7:0] dv, input logic rv);
    d_drv   = dv;
    rst_drv = rv;
    #0.25 rst_drv = ~rv;
    #0.25 rst_drv = rv;
    @(posedge clk);
    record();
    @(negedge clk);
    check_all();
  endtask

  // d changes in the same time step as the rising edge, so the edge must sample the previous d.
  task automatic race_step(input logic [7:0] dv);
    @(posedge clk);
    record();
    d_drv <= dv;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    d_drv   = 8'h00;
    rst_drv = 1'b1;
    @(negedge clk);

    // Reset hold with d=1. Path A follows d and path B stays at its reset value.
    for (int i = 0; i < 5; i++) step(8'h01, 1'b1);

    // Pulse capture: d=1 for a few edges with reset released.
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0);

    // Inter-edge glitches on reset in both polarities.
    for (int i = 0; i < 5; i++) glitch_step(8'h01, 1'b1);
    for (int i = 0; i < 5; i++) glitch_step(8'hC3 + 8'(i), 1'b0);

    // Mid-stream reset: a counting d with reset high for one edge at count 10.
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    for (int c = 1; c <= 20; c++) step(8'(c), c == 10);

    // Release timing: reset released at the edge that samples d=3C.
    for (int i = 0; i < 4; i++) step(8'hFF, 1'b1);
    step(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h10 + 8'(i), 1'b0);

    // Sampling race: d changes in the same time step as the rising edge.
    for (int i = 0; i < 8; i++) race_step(8'h80 + 8'(i * 17));
    step(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(3) == 0) race_step(8'($urandom));
      else                        step(8'($urandom), $urandom_range(7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
